board_io_ctrl: RTL

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced dip-switches plus per-LED off/on/blink/activity drive.
// Define BOARD_IO_CTRL_LED_ACTIVE_LOW_EN to invert the led outputs (reset value all ones).
module board_io_ctrl #(
    parameter int NUM_SW      = 8,
    parameter int NUM_LED     = 16,
    parameter int DB_CYCLES   = 50000,
    parameter int BLINK_DIV_W = 24,
    parameter int STRETCH     = 1000000
) (
    input  logic                       sys0_clk,
    input  logic                       sys0_rst,
    input  logic [NUM_SW-1:0]          usr_sw,
    output logic [NUM_SW-1:0]          sw_q,
    output logic                       sw_chg,
    input  logic                       led_wr,
    input  logic [$clog2(NUM_LED)-1:0] led_idx,
    input  logic [1:0]                 led_mode,
    input  logic [NUM_LED-1:0]         led_act,
    output logic [NUM_LED-1:0]         led
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int ST_W = $clog2(STRETCH + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_RELOAD = ST_W'(STRETCH);

`ifdef BOARD_IO_CTRL_LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    logic [NUM_SW-1:0]      sync_a;
    logic [NUM_SW-1:0]      sync_b;
    logic [DB_W-1:0]        db_cnt [NUM_SW];
    logic [NUM_SW-1:0]      sw_accept;
    logic [1:0]             mode_reg [NUM_LED];
    logic [31:0]            idx_ext;
    logic [BLINK_DIV_W-1:0] blink_cnt;
    logic [ST_W-1:0]        st_cnt [NUM_LED];
    logic [NUM_LED-1:0]     led_lvl;

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= usr_sw;
            sync_b <= sync_a;
        end
    end

    // A bit is accepted on the edge where its run of differing cycles would reach DB_CYCLES.
    always_comb begin
        sw_accept = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            sw_accept[i] = (sync_b[i] != sw_q[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            sw_q   <= '0;
            sw_chg <= 1'b0;
            for (int i = 0; i < NUM_SW; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sw_q   <= sw_q ^ sw_accept;
            sw_chg <= |sw_accept;
            for (int i = 0; i < NUM_SW; i++) begin
                if ((sync_b[i] == sw_q[i]) || sw_accept[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Widened so the range check stays meaningful when NUM_LED is not a power of two.
    assign idx_ext = 32'(led_idx);

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                mode_reg[i] <= 2'b00;
            end
        end else if (led_wr && (idx_ext < 32'(NUM_LED))) begin
            mode_reg[led_idx] <= led_mode;
        end
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Stretch counters run in every mode so a later switch to activity mode sees them.
    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            for (int i = 0; i < NUM_LED; i++) begin
                st_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LED; i++) begin
                if (led_act[i]) begin
                    st_cnt[i] <= ST_RELOAD;
                end else if (st_cnt[i] != '0) begin
                    st_cnt[i] <= st_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        led_lvl = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            case (mode_reg[i])
                2'b00:   led_lvl[i] = 1'b0;
                2'b01:   led_lvl[i] = 1'b1;
                2'b10:   led_lvl[i] = blink_cnt[BLINK_DIV_W-1];
                default: led_lvl[i] = (st_cnt[i] != '0);
            endcase
        end
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            led <= {NUM_LED{LED_INV}};
        end else begin
            led <= led_lvl ^ {NUM_LED{LED_INV}};
        end
    end

endmodule
